// File: rtl/phase_a_issuer_pkg.sv
// Shared types and default sizing for the phase_a issuer: FSM state encoding and
// the production modulus/digit/timeout constants.
package phase_a_issuer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ADD,
    ST_OUT
  } state_t;

  localparam int DEF_SIZE        = 3072;
  localparam int DEF_RADIX       = 78;
  localparam int DEF_ROUNDS_W    = 6;
  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/phase_a_issuer_wide_add.sv
// issuer_wide_add: combinational W-bit adder; the carry out is dropped, so the
// sum wraps modulo 2^W.
module issuer_wide_add #(
  parameter int W = 3151
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/phase_a_issuer.sv
// phase_a_issuer: sequences multi-round phase_a jobs, feeding each round's result plus an addend back in.
// Define PHASE_A_ISSUER_TIMEOUT_EN to bound each WAIT by TIMEOUT_CYC cycles (sticky err_timeout).
module phase_a_issuer
  import phase_a_issuer_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int RADIX       = DEF_RADIX,
  parameter int ROUNDS_W    = DEF_ROUNDS_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [SIZE+RADIX:0]       job_a,
  input  logic [ROUNDS_W-1:0]       job_rounds,
  input  logic                      add_valid,
  output logic                      add_ready,
  input  logic [SIZE+RADIX:0]       add_data,
  output logic [SIZE+RADIX:0]       pa_a,
  output logic                      pa_en,
  input  logic                      pa_done,
  input  logic [SIZE-1:0]           pa_new_a,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SIZE-1:0]           res_data,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int AW = SIZE + RADIX + 1;
  localparam logic [ROUNDS_W-1:0] ONE_ROUND = ROUNDS_W'(1);

  state_t              state;
  logic                issue_second;
  logic [SIZE-1:0]     new_a;
  logic [ROUNDS_W-1:0] round_cnt;
  logic [ROUNDS_W-1:0] round_tgt;
  logic [ROUNDS_W-1:0] round_nxt;
  logic [AW-1:0]       next_a;

  assign round_nxt = round_cnt + ONE_ROUND;
  assign busy      = (state != ST_IDLE);

  issuer_wide_add #(
    .W(AW)
  ) u_wide_add (
    .a   ({{(RADIX + 1){1'b0}}, new_a}),
    .b   (add_data),
    .sum (next_a)
  );

`ifdef PHASE_A_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      issue_second <= 1'b0;
      pa_a         <= '0;
      pa_en        <= 1'b0;
      job_ready    <= 1'b1;
      add_ready    <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      new_a        <= '0;
      round_cnt    <= '0;
      round_tgt    <= '0;
`ifdef PHASE_A_ISSUER_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            pa_a      <= job_a;
            round_tgt <= (job_rounds == '0) ? ONE_ROUND : job_rounds;
            round_cnt <= '0;
            job_ready <= 1'b0;
            pa_en     <= 1'b1;
            state     <= ST_ISSUE;
`ifdef PHASE_A_ISSUER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end

        // pa_en is held for exactly two cycles, then dropped on entry to WAIT
        ST_ISSUE: begin
          if (issue_second) begin
            issue_second <= 1'b0;
            pa_en        <= 1'b0;
            state        <= ST_WAIT;
`ifdef PHASE_A_ISSUER_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end else begin
            issue_second <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (pa_done) begin
            new_a     <= pa_new_a;
            round_cnt <= round_nxt;
            if (round_nxt == round_tgt) begin
              res_valid <= 1'b1;
              res_data  <= pa_new_a;
              state     <= ST_OUT;
            end else begin
              add_ready <= 1'b1;
              state     <= ST_ADD;
            end
          end
`ifdef PHASE_A_ISSUER_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            err_q     <= 1'b1;
            job_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end

        ST_ADD: begin
          if (add_valid) begin
            pa_a      <= next_a;
            add_ready <= 1'b0;
            pa_en     <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          pa_en        <= 1'b0;
          add_ready    <= 1'b0;
          res_valid    <= 1'b0;
          job_ready    <= 1'b1;
          issue_second <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_issuer.sv
// Randomized scoreboard bench for phase_a_issuer with a behavioural phase_a responder
// (fixed 19-cycle latency) and a round-by-round reference of expected pa_a and results.
module tb_phase_a_issuer;

  localparam int SIZE  = 16;
  localparam int RADIX = 4;
  localparam int RW    = 6;
  localparam int AW    = SIZE + RADIX + 1;
  localparam int LAT   = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [AW-1:0]   job_a = '0;
  logic [RW-1:0]   job_rounds = '0;
  logic            add_valid = 1'b0;
  logic            add_ready;
  logic [AW-1:0]   add_data = '0;
  logic [AW-1:0]   pa_a;
  logic            pa_en;
  logic            pa_done;
  logic [SIZE-1:0] pa_new_a;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [SIZE-1:0] res_data;
  logic            busy;
  logic            err_timeout;

  logic            model_done = 1'b0;
  logic            stray_done = 1'b0;
  logic [SIZE-1:0] model_new_a = '0;
  assign pa_done  = model_done | stray_done;
  assign pa_new_a = model_new_a;

  phase_a_issuer #(
    .SIZE(SIZE), .RADIX(RADIX), .ROUNDS_W(RW), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_rounds(job_rounds),
    .add_valid(add_valid), .add_ready(add_ready), .add_data(add_data),
    .pa_a(pa_a), .pa_en(pa_en), .pa_done(pa_done), .pa_new_a(pa_new_a),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [AW-1:0]   exp_pa_q[$];
  logic [SIZE-1:0] exp_res_q[$];
  logic [SIZE-1:0] resp_q[$];
  logic [SIZE-1:0] plan_resp[16];
  logic [AW-1:0]   plan_add[16];
  bit              model_mute = 1'b0;
  int              add_hs = 0;

  // phase_a responder: answers each pa_en rise LAT cycles later with the next planned new_a
  initial begin : model
    int cd;
    bit prev_en;
    logic [SIZE-1:0] pend;
    cd = 0; prev_en = 1'b0; pend = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (!rst_n) begin
        cd = 0; prev_en = 1'b0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          model_done  = 1'b1;
          model_new_a = pend;
        end
      end
      if (pa_en && !prev_en && !model_mute) begin
        if (resp_q.size() == 0) check("model_unplanned_issue", 1, 0);
        else begin
          pend = resp_q.pop_front();
          cd   = LAT;
        end
      end
      prev_en = pa_en;
    end
  end

  initial begin : monitor
    bit prev_en, prev_rv, prev_rr, stab;
    logic [SIZE-1:0] prev_rd;
    logic [AW-1:0] held_a;
    int run;
    prev_en = 0; prev_rv = 0; prev_rr = 0; stab = 0; prev_rd = '0; held_a = '0; run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_en = 0; prev_rv = 0; prev_rr = 0; stab = 0; run = 0;
        continue;
      end
      if (pa_en && !prev_en) begin
        run = 1;
        if (exp_pa_q.size() == 0) check("pa_en_unexpected", 1, 0);
        else check("pa_a", pa_a, exp_pa_q.pop_front());
        held_a = pa_a;
        stab   = 1;
      end else begin
        if (pa_en) run++;
        if (stab) check("pa_a_stable", pa_a, held_a);
      end
      if (!pa_en && prev_en) check("pa_en_width", run, 2);
      if (pa_done && stab && !pa_en) stab = 0;
      if (add_valid && add_ready) add_hs++;
      if (prev_rv && !prev_rr) begin
        check("res_valid_hold", res_valid, 1);
        check("res_data_hold", res_data, prev_rd);
        check("job_ready_in_out", job_ready, 0);
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) check("res_unexpected", 1, 0);
        else check("res_data", res_data, exp_res_q.pop_front());
      end
      prev_en = pa_en; prev_rv = res_valid; prev_rr = res_ready; prev_rd = res_data;
    end
  end

  function automatic bit sel(input int w);
    case (w)
      0: sel = job_ready;
      1: sel = add_ready;
      2: sel = res_valid;
      3: sel = pa_en;
      4: sel = !pa_en;
      default: sel = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (sel(w)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check({"wait_", name}, 0, 1);
  endtask

  task automatic random_plan();
    for (int i = 0; i < 16; i++) begin
      plan_resp[i] = SIZE'($urandom);
      plan_add[i]  = AW'($urandom);
    end
  endtask

  task automatic run_job(input logic [AW-1:0] a, input int rounds, input int hold, input bit stray);
    int eff, hs0;
    logic [AW-1:0] cur;
    eff = (rounds == 0) ? 1 : rounds;
    cur = a;
    for (int r = 0; r < eff; r++) begin
      exp_pa_q.push_back(cur);
      resp_q.push_back(plan_resp[r]);
      cur = AW'(plan_resp[r]) + plan_add[r];
    end
    exp_res_q.push_back(plan_resp[eff-1]);
    hs0 = add_hs;
    if (stray) begin
      stray_done = 1'b1; @(negedge clk); stray_done = 1'b0; @(negedge clk);
      check("idle_stray_done", busy, 0);
    end
    wait_for(0, "job_ready");
    job_valid = 1'b1; job_a = a; job_rounds = RW'(rounds);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("err_cleared_on_accept", err_timeout, 0);
    if (stray) begin
      job_a = ~a; job_rounds = RW'($urandom);
      add_valid = 1'b1; add_data = AW'($urandom);
      repeat (6) @(negedge clk);
      add_valid = 1'b0;
    end
    job_valid = 1'b0;
    for (int r = 0; r < eff - 1; r++) begin
      wait_for(1, "add_ready");
      if (stray) begin
        stray_done = 1'b1; @(negedge clk); stray_done = 1'b0;
        check("add_stray_done", add_ready, 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      add_valid = 1'b1; add_data = plan_add[r];
      @(negedge clk);
      add_valid = 1'b0;
    end
    wait_for(2, "res_valid");
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("add_handshakes", add_hs - hs0, eff - 1);
    check("pa_pulses_left", exp_pa_q.size(), 0);
    check("idle_after_job", job_ready, 1);
  endtask

  // Job whose phase_a never answers: parks the DUT in WAIT
  task automatic start_muted_job(input logic [AW-1:0] a);
    model_mute = 1'b1;
    exp_pa_q.push_back(a);
    wait_for(0, "job_ready_muted");
    job_valid = 1'b1; job_a = a; job_rounds = RW'(2);
    @(negedge clk);
    job_valid = 1'b0;
    check("err_cleared_on_muted_accept", err_timeout, 0);
    wait_for(3, "pa_en_rise");
    wait_for(4, "pa_en_fall");
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_pa_en", pa_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_add_ready", add_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_pa_a", pa_a, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_busy_after", busy, 0);

    random_plan();
    plan_resp[0] = 16'hBEEF;
    run_job(21'h1_2345, 1, 0, 0);

    random_plan();
    plan_add[0] = 21'h1; plan_add[1] = 21'h2;
    run_job(AW'($urandom), 3, 1, 0);

    random_plan();
    run_job(AW'($urandom), 0, 0, 0);

    random_plan();
    run_job(AW'($urandom), 2, 10, 0);

    random_plan();
    run_job(AW'($urandom), 3, 2, 1);

    random_plan();
    plan_resp[0] = 16'hFFFF; plan_add[0] = {AW{1'b1}};
    run_job({AW{1'b1}}, 2, 0, 0);

    for (int j = 0; j < 15; j++) begin
      random_plan();
      run_job(AW'($urandom), $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom));
    end

`ifdef PHASE_A_ISSUER_TIMEOUT_EN
    begin
      int cnt;
      start_muted_job(AW'($urandom));
      cnt = 0;
      while (busy && cnt < 200) begin cnt++; @(negedge clk); end
      check("timeout_wait_cycles", cnt, 64);
      check("timeout_err", err_timeout, 1);
      check("timeout_idle", job_ready, 1);
      repeat (3) @(negedge clk);
      check("timeout_err_sticky", err_timeout, 1);
    end
`endif

    start_muted_job(AW'($urandom));
    repeat (10) @(negedge clk);
    check("wait_still_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_pa_a", pa_a, 0);
    check("midrst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    model_mute = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_result", res_valid, 0);
    check("midrst_idle", job_ready, 1);
    check("midrst_err", err_timeout, 0);

    random_plan();
    run_job(AW'($urandom), 2, 1, 0);

    repeat (5) @(negedge clk);
    check("res_queue_drained", exp_res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
